// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------
// Turns one core load/store request at a time into a word-aligned data-memory
// transaction and returns the aligned, sign/zero-extended load data that feeds
// the writeback select.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   req_valid/ready   core request handshake
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   mem_req/gnt       memory request handshake
//   mem_we            memory write enable (0 for loads)
//   mem_addr          word address {req_addr[31:2], 2'b00}
//   mem_wstrb         byte write strobes (0000 for loads)
//   mem_wdata         lane-steered store data
//   mem_rvalid/rdata  load return, only looked at while waiting for it
//   resp_valid        one-cycle completion pulse
//   resp_err          misaligned, illegal funct3 or timeout (qualified by resp_valid)
//   read_data         extended load data; 0 for stores and errors
//   dbg_state         current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the core must keep its request fields stable while
// req_valid is high and req_ready is low. mem_req stays high with mem_we,
// mem_addr, mem_wstrb and mem_wdata unchanged until the edge where mem_gnt=1.

module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] read_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last counter value before the load is aborted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              ready_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic              resp_err_q;
    logic [31:0]       read_data_q;

    logic              accept;
    logic              req_err;
    logic              timeout_hit;
    logic [3:0]        strb_c;
    logic [31:0]       wdata_c;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_c;

    assign accept      = (state == S_IDLE) && ready_q && req_valid;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Request legality: size/alignment and the funct3 codes valid per direction.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Store lane steering. Replicating the data lets the strobes alone pick
    // the target lane.
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = 32'd0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    strb_c  = 4'b0001 << req_addr[1:0];
                    wdata_c = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    strb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{req_wdata[15:0]}};
                end
                default: begin
                    strb_c  = 4'b1111;
                    wdata_c = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the captured byte offset.
    always_comb begin
        byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_c   = mem_rdata;
        case (funct3_q)
            3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_c = {24'd0, byte_sel};
            3'b101:  load_c = {16'd0, half_sel};
            default: load_c = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = req_err ? S_RESP : S_REQ;
            S_REQ:   if (mem_gnt) state_nx = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_rvalid || timeout_hit) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            cnt         <= '0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            resp_err_q  <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state   <= state_nx;
            // Registered so ready stays low on the first edge out of reset.
            ready_q <= (state_nx == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        we_q     <= req_we;
                        addr_q   <= {req_addr[31:2], 2'b00};
                        wstrb_q  <= strb_c;
                        wdata_q  <= wdata_c;
                        if (req_err) begin
                            resp_err_q  <= 1'b1;
                            read_data_q <= 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        cnt <= '0;
                        if (we_q) begin
                            resp_err_q  <= 1'b0;
                            read_data_q <= 32'd0;
                        end
                    end
                end
                S_WAIT: begin
                    // Data arriving on the final allowed cycle still wins.
                    if (mem_rvalid) begin
                        resp_err_q  <= 1'b0;
                        read_data_q <= load_c;
                    end else if (timeout_hit) begin
                        resp_err_q  <= 1'b1;
                        read_data_q <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign mem_req    = (state == S_REQ);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state == S_RESP);
    assign resp_err   = resp_err_q;
    assign read_data  = read_data_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] read_data;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    // Scoreboard entries: {err, read_data}.
    logic [32:0] exp_q[$];

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .read_data(read_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int a;
        int sz;
        a  = int'(addr[1:0]);
        sz = int'(f3) % 4;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (sz == 1 && (a % 2) != 0) return 1'b1;
        if (sz == 2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int a;
        a = int'(addr[1:0]);
        if (!we) return 4'd0;
        if (f3 == 3'd0) return 4'(1 << a);
        if (f3 == 3'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        if (f3 == 3'd0) return (wdata & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (wdata & 32'hFFFF) * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [32:0] model_resp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata, input logic timed_out);
        int a;
        logic [31:0] b;
        logic [31:0] h;
        a = int'(addr[1:0]);
        if (model_err(we, f3, addr) || timed_out) return {1'b1, 32'd0};
        if (we) return 33'd0;
        b = (rdata >> (8 * a)) & 32'hFF;
        h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return {1'b0, (b >= 32'd128) ? b + 32'hFFFFFF00 : b};
            3'd1:    return {1'b0, (h >= 32'd32768) ? h + 32'hFFFF0000 : h};
            3'd4:    return {1'b0, b};
            3'd5:    return {1'b0, h};
            default: return {1'b0, rdata};
        endcase
    endfunction

    // ---------------- driver ----------------
    // rv_dly: WAIT cycle (0-based) on which rvalid is returned; negative = never.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly,
                          output logic [31:0] obs_data, output logic obs_err);
        logic        err_e;
        logic        timed_out;
        logic [32:0] exp_r;
        logic [32:0] sb_r;
        int          exp_lat;
        int          cyc;
        int          req_cycles;
        int          wait_cycles;
        bit          got;

        err_e     = model_err(we, f3, addr);
        timed_out = !err_e && !we && (rv_dly < 0 || rv_dly >= TIMEOUT);
        exp_r     = model_resp(we, f3, addr, rdata, timed_out);
        if (err_e)          exp_lat = 1;
        else if (we)        exp_lat = gnt_dly + 2;
        else if (timed_out) exp_lat = gnt_dly + 2 + TIMEOUT;
        else                exp_lat = gnt_dly + 3 + rv_dly;
        exp_q.push_back(exp_r);
        obs_data = 32'hDEAD_BEEF;
        obs_err  = 1'bx;

        check1("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        // Scramble request fields so only captured values can be correct.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc = 1;
        req_cycles = 0;
        wait_cycles = 0;
        got = 0;
        while (!got && cyc < 200) begin
            if (resp_valid) begin
                got  = 1;
                sb_r = exp_q.pop_front();
                check("resp_latency", cyc, exp_lat);
                check1("resp_err", resp_err, sb_r[32]);
                check("read_data", read_data, sb_r[31:0]);
                check("req_cycles", req_cycles, err_e ? 0 : gnt_dly + 1);
                check1("mem_req_in_resp", mem_req, 1'b0);
                check1("req_ready_in_resp", req_ready, 1'b0);
                obs_data = read_data;
                obs_err  = resp_err;
            end else if (mem_req) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check1("mem_we", mem_we, we);
                check({"mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, model_strb(we, f3, addr)});
                if (we) check("mem_wdata", mem_wdata, model_wdata(f3, wdata));
                check1("req_ready_in_req", req_ready, 1'b0);
                mem_gnt    = (req_cycles == gnt_dly);
                // Stray rvalid while requesting must be ignored.
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                req_cycles++;
            end else begin
                mem_rvalid = (rv_dly >= 0 && wait_cycles == rv_dly);
                mem_rdata  = mem_rvalid ? rdata : $urandom;
                wait_cycles++;
            end
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            cyc++;
        end

        if (!got) begin
            void'(exp_q.pop_front());
            check("resp_budget", cyc, exp_lat);
        end else begin
            check1("resp_pulse_end", resp_valid, 1'b0);
            check1("req_ready_after", req_ready, 1'b1);
            check("read_data_hold", read_data, obs_data);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic        e;

        // Reset with a pending request.
        rst_n = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check1("rst_req_ready", req_ready, 1'b0);
            check1("rst_mem_req", mem_req, 1'b0);
            check1("rst_resp_valid", resp_valid, 1'b0);
            check("rst_read_data", read_data, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check1("rel_req_ready", req_ready, 1'b1);
        check({"rel_state"}, {30'd0, dbg_state}, 32'd0);
        req_valid = 1'b0;

        // Directed cases.
        do_txn(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0, d, e);
        check("sb_read_data", d, 32'd0);
        check1("sb_err", e, 1'b0);
        do_txn(1'b0, 3'd0, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0, d, e);
        check("lb_value", d, 32'hFFFF_FFF0);
        do_txn(1'b0, 3'd4, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0, d, e);
        check("lbu_value", d, 32'h0000_00F0);
        do_txn(1'b0, 3'd1, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0, d, e);
        check("lh_value", d, 32'h0000_12F0);
        do_txn(1'b0, 3'd2, 32'h0000_3001, 32'd0, 32'h1111_1111, 0, 0, d, e);
        check1("lw_misaligned_err", e, 1'b1);
        do_txn(1'b1, 3'd1, 32'h0000_3003, 32'h0000_BEEF, 32'd0, 0, 0, d, e);
        check1("sh_misaligned_err", e, 1'b1);
        do_txn(1'b0, 3'd2, 32'h0000_6000, 32'd0, 32'h5555_AAAA, 3, -1, d, e);
        check1("timeout_err", e, 1'b1);
        check("timeout_data", d, 32'd0);
        do_txn(1'b0, 3'd2, 32'h0000_6004, 32'd0, 32'h5555_AAAA, 1, TIMEOUT - 1, d, e);
        check("last_cycle_data", d, 32'h5555_AAAA);

        // Reset while a load waits for data.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_4000;
        tick();
        req_valid = 1'b0;
        check1("mr_mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({"mr_in_wait"}, {30'd0, dbg_state}, 32'd2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("mr_rst_ready", req_ready, 1'b0);
        check1("mr_rst_resp", resp_valid, 1'b0);
        check1("mr_rst_mem_req", mem_req, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check1("mr_ready_after", req_ready, 1'b1);
        check1("mr_no_resp", resp_valid, 1'b0);
        tick();
        check1("mr_no_resp2", resp_valid, 1'b0);
        do_txn(1'b1, 3'd2, 32'h0000_5008, 32'h0123_4567, 32'd0, 0, 0, d, e);
        check1("mr_sw_err", e, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we   = 1'($urandom);
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) + (we ? 3'd0 : 3'($urandom_range(0, 1) * 4));
            addr = $urandom;
            do_txn(we, f3, addr, $urandom, $urandom, $urandom_range(0, 3),
                   int'($urandom_range(0, 6)) - 1, d, e);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
